// File: rtl/sl28_pkg.sv
// Shared definitions for the interrupt controller: CSR register offsets,
// pulse generator state encoding and a small elaboration-time helper.
package sl28_pkg;

    localparam logic [1:0] OFF_IE   = 2'd0;
    localparam logic [1:0] OFF_IP   = 2'd1;
    localparam logic [1:0] OFF_EDGE = 2'd2;
    localparam logic [1:0] OFF_POL  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } pulse_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/irq_pulse_gen.sv
// Turns a trigger into a fixed-width irq pulse followed by a fixed low holdoff.
// Triggers arriving while busy can be remembered and replayed once idle again.
module irq_pulse_gen
    import sl28_pkg::*;
#(
    parameter int PULSE_CYCLES   = 4,
    parameter int HOLDOFF_CYCLES = 4,
    parameter bit MISSED_EN      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic trigger,
    output logic irq
);

    localparam int CNT_W = $clog2(max_int(PULSE_CYCLES, HOLDOFF_CYCLES) + 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    pulse_state_t     state;
    pulse_state_t     state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             missed;
    logic             missed_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            missed <= 1'b0;
            irq    <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            missed <= missed_next;
            irq    <= (state_next == ST_PULSE);
        end
    end

    // The counter holds the remaining cycles of the current phase minus one.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        missed_next = missed;
        case (state)
            ST_IDLE: begin
                if (trigger || missed) begin
                    state_next  = ST_PULSE;
                    cnt_next    = PULSE_LOAD;
                    missed_next = 1'b0;
                end
            end
            ST_PULSE: begin
                if (MISSED_EN && trigger) begin
                    missed_next = 1'b1;
                end
                if (cnt == '0) begin
                    state_next = ST_HOLDOFF;
                    cnt_next   = HOLD_LOAD;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            ST_HOLDOFF: begin
                if (MISSED_EN && trigger) begin
                    missed_next = 1'b1;
                end
                if (cnt == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            default: begin
                state_next  = ST_IDLE;
                cnt_next    = '0;
                missed_next = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-channel edge/level and polarity select, pending latch
// with write-1-to-clear, level output and pulsed irq. Macro IRQ_CTRL_RETRIGGER_EN
// makes a pending enabled interrupt re-pulse for as long as it stays unacknowledged.
module irq_ctrl
    import sl28_pkg::*;
#(
    parameter logic [4:0] BASE_ADDR      = 5'h1c,
    parameter int         NUM_INTS       = 8,
    parameter int         PULSE_CYCLES   = 4,
    parameter int         HOLDOFF_CYCLES = 4,
    parameter logic [7:0] DFL_EDGE       = 8'hff
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          csr_a,
    input  logic [7:0]          csr_di,
    input  logic                csr_we,
    output logic [7:0]          csr_do,
    input  logic [NUM_INTS-1:0] irqs_in,
    output logic                irq,
    output logic                irq_level
);

    localparam logic [4:0] ADDR_IE   = BASE_ADDR + {3'b000, OFF_IE};
    localparam logic [4:0] ADDR_IP   = BASE_ADDR + {3'b000, OFF_IP};
    localparam logic [4:0] ADDR_EDGE = BASE_ADDR + {3'b000, OFF_EDGE};
    localparam logic [4:0] ADDR_POL  = BASE_ADDR + {3'b000, OFF_POL};

    logic [NUM_INTS-1:0] ie;
    logic [NUM_INTS-1:0] ip;
    logic [NUM_INTS-1:0] edge_sel;
    logic [NUM_INTS-1:0] pol;
    logic [NUM_INTS-1:0] irqs_prev;
    logic [NUM_INTS-1:0] active_now;
    logic [NUM_INTS-1:0] active_prev;
    logic [NUM_INTS-1:0] edge_evt;
    logic [NUM_INTS-1:0] set_bits;
    logic [NUM_INTS-1:0] masked;
    logic [NUM_INTS-1:0] wdata;
    logic                sel_ie;
    logic                sel_ip;
    logic                sel_edge;
    logic                sel_pol;
    logic                trigger;

    function automatic logic [7:0] zext(input logic [NUM_INTS-1:0] v);
        logic [7:0] r;
        r = '0;
        r[NUM_INTS-1:0] = v;
        return r;
    endfunction

    assign sel_ie   = (csr_a == ADDR_IE);
    assign sel_ip   = (csr_a == ADDR_IP);
    assign sel_edge = (csr_a == ADDR_EDGE);
    assign sel_pol  = (csr_a == ADDR_POL);
    assign wdata    = csr_di[NUM_INTS-1:0];

    always_comb begin
        csr_do = ({8{sel_ie}}   & zext(ie))
               | ({8{sel_ip}}   & zext(ip))
               | ({8{sel_edge}} & zext(edge_sel))
               | ({8{sel_pol}}  & zext(pol));
    end

    // Both samples go through the current POL, so changing POL alone never looks like an edge.
    assign active_now  = irqs_in ^ pol;
    assign active_prev = irqs_prev ^ pol;
    assign edge_evt    = active_now & ~active_prev;
    assign set_bits    = (edge_sel & edge_evt) | (~edge_sel & active_now);
    assign masked      = ip & ie;
    assign irq_level   = |masked;

    always_ff @(posedge clk) begin
        if (rst) begin
            ie        <= '0;
            ip        <= '0;
            edge_sel  <= DFL_EDGE[NUM_INTS-1:0];
            pol       <= '0;
            irqs_prev <= irqs_in;
        end else begin
            irqs_prev <= irqs_in;
            if (csr_we && sel_ie) begin
                ie <= wdata;
            end
            if (csr_we && sel_edge) begin
                edge_sel <= wdata;
            end
            if (csr_we && sel_pol) begin
                pol <= wdata;
            end
            // A new set wins over a clear landing in the same cycle.
            if (csr_we && sel_ip) begin
                ip <= (ip & ~wdata) | set_bits;
            end else begin
                ip <= ip | set_bits;
            end
        end
    end

`ifdef IRQ_CTRL_RETRIGGER_EN
    localparam bit MISSED_EN = 1'b0;

    assign trigger = |masked;
`else
    localparam bit MISSED_EN = 1'b1;

    logic [NUM_INTS-1:0] masked_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            masked_prev <= '0;
        end else begin
            masked_prev <= masked;
        end
    end

    assign trigger = |(masked & ~masked_prev);
`endif

    irq_pulse_gen #(
        .PULSE_CYCLES  (PULSE_CYCLES),
        .HOLDOFF_CYCLES(HOLDOFF_CYCLES),
        .MISSED_EN     (MISSED_EN)
    ) u_pulse_gen (
        .clk    (clk),
        .rst    (rst),
        .trigger(trigger),
        .irq    (irq)
    );

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 5'h1c, CSR base address of the 4-register window.
REQ-002 SHALL have parameter NUM_INTS, default 8, interrupt channel count, legal range 1..8.
REQ-003 SHALL have parameter PULSE_CYCLES, default 4, irq pulse width in clk cycles, legal value >=1.
REQ-004 SHALL have parameter HOLDOFF_CYCLES, default 4, minimum low time after a pulse, legal value >=1.
REQ-005 SHALL have parameter DFL_EDGE, default all ones, reset value of EDGE.
REQ-006 SHALL have ports: clk in 1, clock; rst in 1, reset (synchronous, active-high); csr_a in 5, register address; csr_di in 8, write data; csr_we in 1, write strobe; csr_do out 8, read data; irqs_in in NUM_INTS, already-synchronised sources; irq out 1, pulsed interrupt; irq_level out 1, OR of masked pending bits.

Function
REQ-007 SHALL map registers: BASE+0 IE; BASE+1 IP (read pending, write-1-to-clear); BASE+2 EDGE (1=edge, 0=level); BASE+3 POL (1=active-low/falling).
REQ-008 SHALL drive csr_do combinationally with the addressed register, zero-extended above NUM_INTS, and 8'h00 for any other address (OR-bus).
REQ-009 SHALL apply CSR writes (csr_we=1 with matching address) at the next clk edge; bits >= NUM_INTS ignored.
REQ-010 SHALL compute per channel active=in^POL; edge event = active_now & ~active_prev, with prev raw input registered every cycle, so that POL writes never create an event.
REQ-011 SHALL set IP[i] next cycle on an edge event (EDGE[i]=1) or every cycle while active (EDGE[i]=0); a set takes priority over a simultaneous W1C.
REQ-012 SHALL latch IP regardless of IE; irq_level = |(IP & IE), combinational.
REQ-013 SHALL run FSM IDLE -> PULSE (irq=1, exactly PULSE_CYCLES cycles) -> HOLDOFF (irq=0, exactly HOLDOFF_CYCLES cycles) -> IDLE; irq registered.
REQ-014 SHALL leave IDLE toward PULSE when a trigger (REQ-020/021) is present; irq rises the cycle after the IP bit is visible.
REQ-015 SHALL use one down-counter of width $clog2(max(PULSE_CYCLES,HOLDOFF_CYCLES)+1), no wrap past zero.
REQ-016 SHALL, without retrigger, hold a "missed" flag for any newly-set masked bit arriving during PULSE/HOLDOFF and enter PULSE from IDLE one cycle after HOLDOFF ends.
REQ-017 SHALL keep a running pulse at full length if IP is cleared or IE written mid-pulse.

Reset
REQ-018 SHALL on rst: IE=0, IP=0, EDGE=DFL_EDGE, POL=0, FSM=IDLE, counter=0, missed=0, irq=0, prev loaded from irqs_in (no edge in first cycle after rst).
REQ-019 SHALL abort PULSE/HOLDOFF immediately on rst, with irq=0 in the cycle following the rst edge.

Configuration
REQ-020 SHALL, with IRQ_CTRL_RETRIGGER_EN defined, trigger from IDLE whenever |(IP & IE)=1, so a pending, unacknowledged interrupt re-pulses every PULSE_CYCLES+HOLDOFF_CYCLES+1 cycles.
REQ-021 SHALL, without IRQ_CTRL_RETRIGGER_EN, trigger only on a newly-set masked bit ((IP&IE) & ~prev(IP&IE) nonzero) or missed=1; steady pending produces one pulse.

Structure
REQ-022 SHALL place register offsets (IE=0, IP=1, EDGE=2, POL=3) and FSM state encoding in shared package sl28_pkg.
REQ-023 SHALL contain one sub-module irq_pulse_gen (FSM, counter, missed flag) taking a trigger and producing irq.

Verification
REQ-024 SHALL cover: IE=8'h01, EDGE=8'h01, POL=0, irqs_in[0] 0->1 -> IP=8'h01 next cycle, irq high 4 cycles, then low >=4 cycles.
REQ-025 SHALL cover: level channel 2 (EDGE=8'hFB) held active, W1C 8'h04 -> IP[2] stays 1; release input then W1C -> IP=8'h00.
REQ-026 SHALL cover: POL write 8'h01 while irqs_in[0]=0 -> no IP set; then 0->1 on input -> no set, 1->0 -> IP[0]=1.
REQ-027 SHALL cover: ch1 edge during PULSE of ch0, non-retrigger build -> second pulse starts exactly 1 cycle after HOLDOFF ends.
REQ-028 SHALL cover: retrigger build, IP[0]=1 unacknowledged -> irq pulses period 9 cycles; W1C stops further pulses, current one completes.
REQ-029 SHALL cover: rst asserted mid-PULSE -> irq=0, IP=0, csr_do at BASE+2 reads DFL_EDGE.
